arb_grant_sequencer: RTL
========================

# arb_grant_sequencer

Registered grant sequencer that sits directly downstream of the 16-bit right (lowest-index-first) priority arbiter in the ALU resource-sharing path. It captures a snapshot of the 16 request lines and serves every captured requester one at a time, in right-arbiter priority order. Each grant is held for a bounded number of cycles and is then acknowledged. No new requests are admitted until the current batch drains, so a low-index requester cannot starve high-index ones.

## Interface
- N, 16, number of requesters (fixed at 16; index width 4)
- HOLD_CYC, 4, maximum cycles a grant is held; legal range 1..256

- clk  input  1  rising-edge clock
- rst_n  input  1  reset; one clock; asynchronous, active-low
- req  input  16  level requests; a requester holds its bit until acked or until it withdraws
- rel  input  1  early release by the current grantee; ignored when gnt_vld=0
- gnt  output  16  registered one-hot grant; all zeros when idle
- gnt_idx  output  4  binary index of the set gnt bit; 0 when idle
- gnt_vld  output  1  a grant is active
- ack  output  16  one-cycle one-hot pulse marking a normal grant completion
- busy  output  1  a batch is in progress (the state is HOLD)

## Operation
- Internal registers:
  - state: IDLE or HOLD.
  - pend[15:0]: the captured batch.
  - cnt[7:0]: hold counter.
- Priority function: lowest(x) = x & ~(x-1), i.e. the lowest set bit, the same rule as the upstream right arbiter. The result is zero when x is zero.
- IDLE, with req != 0:
  - pend <= req; gnt <= lowest(req); gnt_idx <= encode; gnt_vld <= 1; cnt <= HOLD_CYC-1; go to HOLD.
- IDLE, with req == 0: remain in IDLE with all outputs 0.
- HOLD, release condition: cnt==0, or rel==1, or the req bit of the grantee drops.
- HOLD, without a release: cnt decrements by one.
- HOLD, on release:
  - Compute nxt = pend & ~gnt & req. A pending requester that withdrew before its turn is dropped without an ack.
  - pend <= nxt.
  - ack <= gnt if the release was caused by cnt==0 or rel. ack <= 0 if the release was caused by withdrawal of the grantee.
  - If nxt != 0: gnt <= lowest(nxt); cnt <= HOLD_CYC-1; stay in HOLD. Grants run back-to-back with no gap cycle.
  - If nxt == 0: gnt, gnt_idx, gnt_vld <= 0; go to IDLE.
- Simultaneous release causes (for example cnt==0 together with rel): one release and at most one ack. Withdrawal of the grantee takes precedence and suppresses the ack.
- New req bits that rise during HOLD are not added to pend. They are sampled at the next IDLE cycle.
- Invariants:
  - gnt is zero or one-hot.
  - gnt is always a subset of pend.
  - ack is zero or one-hot.
  - busy == gnt_vld.

## Timing
- Reset (async assert; deassert synchronous to clk): state=IDLE, pend=0, cnt=0, gnt=0, gnt_idx=0, gnt_vld=0, ack=0, busy=0.
- Latency: req is sampled in IDLE at edge t. gnt_vld is high from t+1.
- Grant length: without rel, a grant lasts exactly HOLD_CYC cycles. With rel sampled at an edge, the grant lasts at least 1 cycle.
- ack is asserted in the first cycle after the grant ends, which is the same cycle the next grant (if any) is visible.
- Back-to-back batches: at least one IDLE cycle separates the last grant of one batch from the first grant of the next.
- HOLD_CYC=1: each grant lasts 1 cycle; rel has no additional effect.
- Reset asserted mid-batch clears everything immediately. No ack is produced for the interrupted grant.

## Test plan
- Single requester: HOLD_CYC=4; req=16'h0010 from t0 and held → gnt=16'h0010, gnt_idx=4, gnt_vld high for cycles t0+1..t0+4; ack=16'h0010 at t0+5; IDLE at t0+5; regrant at t0+6 if req is still high.
- Batch order: req=16'h8005 held, HOLD_CYC=2 → grants 0x0001, 0x0004, 0x8000 for 2 cycles each, contiguous; acks in the same order; busy high for 6 cycles.
- Late arrival and withdrawal: batch 16'h0003 in progress; bit 2 rises mid-batch → not served until after the batch IDLE cycle. Bit 1 dropped before its turn → no grant and no ack for bit 1.
- Early release: HOLD_CYC=8, req=16'h0006, rel pulsed in the 2nd cycle of the bit-1 grant → bit-1 grant lasts 2 cycles, ack 0x0002; bit-2 grant starts the next cycle and lasts 8 cycles.
- Grantee withdrawal: req=16'h0001 with grant active; req drops → grant ends the next edge, ack stays 0, return to IDLE.
- Reset mid-grant: drop rst_n asynchronously during HOLD → all outputs 0 without waiting for a clk edge; after release, req=16'hFFFF serves bits 0..15 in order.

Source files
------------

// File: rtl/arb_grant_sequencer_if.sv
// Request/grant bundle between the requesters and the grant sequencer.
// The master side drives requests and early release; the slave side returns grants and acks.
interface arb_grant_sequencer_if;
    logic [15:0] req;
    logic        rel;
    logic [15:0] gnt;
    logic [3:0]  gnt_idx;
    logic        gnt_vld;
    logic [15:0] ack;
    logic        busy;

    modport master (
        output req,
        output rel,
        input  gnt,
        input  gnt_idx,
        input  gnt_vld,
        input  ack,
        input  busy
    );

    modport slave (
        input  req,
        input  rel,
        output gnt,
        output gnt_idx,
        output gnt_vld,
        output ack,
        output busy
    );
endinterface

// File: rtl/arb_grant_sequencer.sv
// Batch grant sequencer: snapshots the 16 request lines and grants each captured
// requester in lowest-index-first order, holding each grant for at most HOLD_CYC cycles.
module arb_grant_sequencer #(
    parameter int unsigned HOLD_CYC = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    arb_grant_sequencer_if.slave  bus
);

    localparam logic [7:0] CNT_INIT = 8'(HOLD_CYC - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t      r_state;
    logic [15:0] r_pend;
    logic [7:0]  r_cnt;
    logic [15:0] r_gnt;
    logic [3:0]  r_gnt_idx;
    logic        r_gnt_vld;
    logic [15:0] r_ack;

    logic [15:0] w_lowest_req;
    logic [15:0] w_nxt;
    logic [15:0] w_lowest_nxt;
    logic        w_withdraw;
    logic        w_release;

    // Same rule as the upstream right arbiter; yields zero for a zero vector.
    function automatic logic [15:0] lowest(input logic [15:0] x);
        lowest = x & ~(x - 16'd1);
    endfunction

    // One-hot to binary; OR-reduction needs no priority since the input is one-hot.
    function automatic logic [3:0] encode(input logic [15:0] x);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (x[i]) begin
                idx = idx | 4'(i);
            end else begin
                idx = idx;
            end
        end
        encode = idx;
    endfunction

    assign w_lowest_req = lowest(bus.req);
    assign w_nxt        = r_pend & ~r_gnt & bus.req;
    assign w_lowest_nxt = lowest(w_nxt);
    assign w_withdraw   = ~|(r_gnt & bus.req);
    assign w_release    = (r_cnt == 8'd0) | bus.rel | w_withdraw;

    // Batch capture, grant hold/advance and ack generation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_pend    <= 16'h0000;
            r_cnt     <= 8'd0;
            r_gnt     <= 16'h0000;
            r_gnt_idx <= 4'd0;
            r_gnt_vld <= 1'b0;
            r_ack     <= 16'h0000;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_ack <= 16'h0000;
                    if (|bus.req) begin
                        r_pend    <= bus.req;
                        r_gnt     <= w_lowest_req;
                        r_gnt_idx <= encode(w_lowest_req);
                        r_gnt_vld <= 1'b1;
                        r_cnt     <= CNT_INIT;
                        r_state   <= ST_HOLD;
                    end else begin
                        r_pend    <= 16'h0000;
                        r_gnt     <= 16'h0000;
                        r_gnt_idx <= 4'd0;
                        r_gnt_vld <= 1'b0;
                        r_cnt     <= 8'd0;
                        r_state   <= ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    if (w_release) begin
                        r_pend <= w_nxt;
                        // A grantee that withdrew is not acknowledged, even if its time was also up.
                        r_ack  <= w_withdraw ? 16'h0000 : r_gnt;
                        if (|w_nxt) begin
                            r_gnt     <= w_lowest_nxt;
                            r_gnt_idx <= encode(w_lowest_nxt);
                            r_gnt_vld <= 1'b1;
                            r_cnt     <= CNT_INIT;
                            r_state   <= ST_HOLD;
                        end else begin
                            r_gnt     <= 16'h0000;
                            r_gnt_idx <= 4'd0;
                            r_gnt_vld <= 1'b0;
                            r_cnt     <= 8'd0;
                            r_state   <= ST_IDLE;
                        end
                    end else begin
                        r_ack <= 16'h0000;
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_pend    <= 16'h0000;
                    r_cnt     <= 8'd0;
                    r_gnt     <= 16'h0000;
                    r_gnt_idx <= 4'd0;
                    r_gnt_vld <= 1'b0;
                    r_ack     <= 16'h0000;
                end
            endcase
        end
    end

    assign bus.gnt     = r_gnt;
    assign bus.gnt_idx = r_gnt_idx;
    assign bus.gnt_vld = r_gnt_vld;
    assign bus.ack     = r_ack;
    assign bus.busy    = (r_state == ST_HOLD);

endmodule
